// File: rtl/sram_march_bist_if.sv
// Port bundle between a March BIST controller and one BIST port of the SRAM macro plus its DFT status.
// master = controller side, slave = macro/status side.
interface sram_march_bist_if #(
   parameter int unsigned AddrWidth = 10,
   parameter int unsigned DataWidth = 32
);
   logic                 start_i;
   logic                 bist_en_o;
   logic                 bist_men_o;
   logic                 bist_wen_o;
   logic                 bist_ren_o;
   logic [AddrWidth-1:0] bist_addr_o;
   logic [DataWidth-1:0] bist_din_o;
   logic [DataWidth-1:0] bist_bm_o;
   logic [DataWidth-1:0] dout_i;
   logic                 busy_o;
   logic                 done_o;
   logic                 fail_o;
   logic [AddrWidth-1:0] fail_addr_o;
   logic [2:0]           fail_elem_o;

   modport master (
      input  start_i, dout_i,
      output bist_en_o, bist_men_o, bist_wen_o, bist_ren_o, bist_addr_o, bist_din_o,
             bist_bm_o, busy_o, done_o, fail_o, fail_addr_o, fail_elem_o
   );

   modport slave (
      output start_i, dout_i,
      input  bist_en_o, bist_men_o, bist_wen_o, bist_ren_o, bist_addr_o, bist_din_o,
             bist_bm_o, busy_o, done_o, fail_o, fail_addr_o, fail_elem_o
   );
endinterface

// File: rtl/sram_march_bist.sv
// March C- BIST controller for one SRAM port: a generator issues one op per cycle into registered
// outputs, and each read is compared one edge after the macro captures it; first failure is latched.
module sram_march_bist #(
   parameter int unsigned          AddrWidth  = 10,
   parameter int unsigned          DataWidth  = 32,
   parameter logic [DataWidth-1:0] Background = '0
) (
   input logic                clk_i,
   input logic                rst_ni,
   sram_march_bist_if.master  bus
);
   localparam logic [AddrWidth-1:0] AddrMax = {AddrWidth{1'b1}};
   localparam logic [AddrWidth-1:0] AddrOne = {{(AddrWidth-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE} state_t;
   state_t r_state, w_state_nxt;

   logic                 r_gen, r_phase;
   logic [2:0]           r_elem;
   logic [AddrWidth-1:0] r_addr;

   logic                 r_men, r_wen, r_ren;
   logic [AddrWidth-1:0] r_op_addr;
   logic [DataWidth-1:0] r_din, r_op_exp;
   logic [2:0]           r_op_elem;

   logic                 r_cmp_vld;
   logic [DataWidth-1:0] r_cmp_exp;
   logic [AddrWidth-1:0] r_cmp_addr;
   logic [2:0]           r_cmp_elem;

   logic                 r_busy, r_done, r_fail;
   logic [AddrWidth-1:0] r_fail_addr;
   logic [2:0]           r_fail_elem;

   logic                 w_start, w_is_read, w_last_op, w_down, w_addr_tc, w_next_down, w_one, w_mismatch;
   logic [DataWidth-1:0] w_val;

   assign w_start     = bus.start_i && (r_state == ST_IDLE || r_state == ST_DONE);
   assign w_is_read   = (r_elem == 3'd5) || (r_elem != 3'd0 && !r_phase);
   assign w_last_op   = (r_elem == 3'd0) || (r_elem == 3'd5) || r_phase;
   assign w_down      = (r_elem == 3'd3) || (r_elem == 3'd4);
   assign w_addr_tc   = w_down ? (r_addr == '0) : (r_addr == AddrMax);
   assign w_next_down = (r_elem == 3'd2) || (r_elem == 3'd3);
   // Reads of elements 2/4 and writes of elements 1/3 use the inverted background
   assign w_one       = w_is_read ? (r_elem == 3'd2 || r_elem == 3'd4) : (r_elem == 3'd1 || r_elem == 3'd3);
   assign w_val       = w_one ? ~Background : Background;
   assign w_mismatch  = r_cmp_vld && (bus.dout_i != r_cmp_exp);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) r_state <= ST_IDLE;
      else         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE, ST_DONE: if (w_start) w_state_nxt = ST_RUN;
         ST_RUN:   if (r_men && r_op_elem == 3'd5 && r_op_addr == AddrMax) w_state_nxt = ST_DRAIN;
         ST_DRAIN: w_state_nxt = ST_DONE;
         default:  w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_gen   <= 1'b0;
         r_phase <= 1'b0;
         r_elem  <= 3'd0;
         r_addr  <= '0;
      end else if (w_start) begin
         r_gen   <= 1'b1;
         r_phase <= 1'b0;
         r_elem  <= 3'd0;
         r_addr  <= '0;
      end else if (r_gen) begin
         if (!w_last_op) begin
            r_phase <= 1'b1;
         end else begin
            r_phase <= 1'b0;
            if (w_addr_tc) begin
               if (r_elem == 3'd5) r_gen  <= 1'b0;
               else                r_elem <= r_elem + 3'd1;
               r_addr <= w_next_down ? AddrMax : '0;
            end else begin
               r_addr <= w_down ? r_addr - AddrOne : r_addr + AddrOne;
            end
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_men      <= 1'b0;
         r_wen      <= 1'b0;
         r_ren      <= 1'b0;
         r_op_addr  <= '0;
         r_din      <= '0;
         r_op_exp   <= '0;
         r_op_elem  <= 3'd0;
         r_cmp_vld  <= 1'b0;
         r_cmp_exp  <= '0;
         r_cmp_addr <= '0;
         r_cmp_elem <= 3'd0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_men      <= r_gen;
         r_wen      <= r_gen && !w_is_read;
         r_ren      <= r_gen && w_is_read;
         r_op_addr  <= r_gen ? r_addr : '0;
         r_din      <= (r_gen && !w_is_read) ? w_val : '0;
         r_op_exp   <= w_val;
         r_op_elem  <= r_elem;
         r_cmp_vld  <= r_ren;
         r_cmp_exp  <= r_op_exp;
         r_cmp_addr <= r_op_addr;
         r_cmp_elem <= r_op_elem;
         r_busy     <= (w_state_nxt == ST_RUN) || (w_state_nxt == ST_DRAIN);
         r_done     <= (w_state_nxt == ST_DONE);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_fail      <= 1'b0;
         r_fail_addr <= '0;
         r_fail_elem <= 3'd0;
      end else if (w_start) begin
         r_fail      <= 1'b0;
         r_fail_addr <= '0;
         r_fail_elem <= 3'd0;
      end else if (w_mismatch && !r_fail) begin
         r_fail      <= 1'b1;
         r_fail_addr <= r_cmp_addr;
         r_fail_elem <= r_cmp_elem;
      end
   end

   assign bus.bist_en_o   = r_busy;
   assign bus.bist_men_o  = r_men;
   assign bus.bist_wen_o  = r_wen;
   assign bus.bist_ren_o  = r_ren;
   assign bus.bist_addr_o = r_op_addr;
   assign bus.bist_din_o  = r_din;
   assign bus.bist_bm_o   = {DataWidth{r_men}};
   assign bus.busy_o      = r_busy;
   assign bus.done_o      = r_done;
   assign bus.fail_o      = r_fail;
   assign bus.fail_addr_o = r_fail_addr;
   assign bus.fail_elem_o = r_fail_elem;
endmodule
